// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared binary32 constants, rounding modes and result record for the fp32 multiplier
package fp_mul_pkg;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int SIG_W    = 24;
    localparam int PROD_W   = 48;
    localparam int EXP_BIAS = 127;
    localparam logic [31:0] QNAN       = 32'h7FC00000;
    localparam logic [31:0] POS_INF    = 32'h7F800000;
    localparam logic [31:0] NEG_INF    = 32'hFF800000;
    localparam logic [31:0] MAX_FINITE = 32'h7F7FFFFF;
    typedef enum logic [2:0] {RNE, RTZ, RDN, RUP, RMM} rmode_e;
    typedef struct packed {
        logic [31:0] z;
        logic        ovrf;
        logic        udrf;
    } res_t;
    function automatic rmode_e decode_mode(input logic [3:0] m);
        return (m > 4'd4) ? RNE : rmode_e'(m[2:0]);
    endfunction
endpackage

// File: rtl/fp_round.sv
// fp_round: rounds a normalized 24-bit significand using guard/round/sticky and the rounding mode
module fp_round
    import fp_mul_pkg::*;
(
    input  logic             sign,
    input  logic [SIG_W-1:0] sig,
    input  logic             guard,
    input  logic             round,
    input  logic             sticky,
    input  rmode_e           mode,
    output logic [SIG_W-1:0] sig_out,
    output logic             carry
);
    logic             inc;
    logic [SIG_W:0]   sum;
    // Pick the increment from the discarded bits, add it, and renormalize on carry-out
    always_comb begin
        inc = 1'b0;
        case (mode)
            RNE:     inc = guard & (round | sticky | sig[0]);
            RDN:     inc = sign & (guard | round | sticky);
            RUP:     inc = ~sign & (guard | round | sticky);
            RMM:     inc = guard;
            default: inc = 1'b0;
        endcase
        sum     = {1'b0, sig} + {{SIG_W{1'b0}}, inc};
        carry   = sum[SIG_W];
        sig_out = carry ? sum[SIG_W:1] : sum[SIG_W-1:0];
    end
endmodule

// File: rtl/fp32_mul_pipe.sv
// fp32_mul_pipe: three-stage pipelined binary32 multiplier with flush-to-zero and five rounding modes
module fp32_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  r_mode,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    output logic        out_valid,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf
);
    logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, any_nan, any_inf;
    assign x_zero  = fp_X[MAN_W +: EXP_W] == '0;
    assign y_zero  = fp_Y[MAN_W +: EXP_W] == '0;
    assign x_inf   = (&fp_X[MAN_W +: EXP_W]) & ~(|fp_X[MAN_W-1:0]);
    assign y_inf   = (&fp_Y[MAN_W +: EXP_W]) & ~(|fp_Y[MAN_W-1:0]);
    assign x_nan   = (&fp_X[MAN_W +: EXP_W]) & (|fp_X[MAN_W-1:0]);
    assign y_nan   = (&fp_Y[MAN_W +: EXP_W]) & (|fp_Y[MAN_W-1:0]);
    assign any_nan = x_nan | y_nan | (x_inf & y_zero) | (y_inf & x_zero);
    assign any_inf = (x_inf | y_inf) & ~any_nan;

    logic              s1_v, s1_sign, s1_nan, s1_inf, s1_zero;
    logic signed [9:0] s1_exp;
    logic [PROD_W-1:0] s1_prod;
    rmode_e            s1_mode;
    // Stage 1: classify operands, sign, biased exponent sum and raw significand product
    always_ff @(posedge clk) begin
        s1_v    <= in_valid & ~rst;
        s1_sign <= fp_X[31] ^ fp_Y[31];
        s1_nan  <= any_nan;
        s1_inf  <= any_inf;
        s1_zero <= (x_zero | y_zero) & ~any_nan;
        s1_exp  <= 10'(fp_X[MAN_W +: EXP_W]) + 10'(fp_Y[MAN_W +: EXP_W]) - 10'(EXP_BIAS);
        s1_prod <= {1'b1, fp_X[MAN_W-1:0]} * {1'b1, fp_Y[MAN_W-1:0]};
        s1_mode <= decode_mode(r_mode);
    end

    logic              s2_v, s2_sign, s2_nan, s2_inf, s2_zero, s2_g, s2_r, s2_st;
    logic signed [9:0] s2_exp;
    logic [SIG_W-1:0]  s2_sig;
    rmode_e            s2_mode;
    // Stage 2: normalize the product so its leading one sits at the top of the 24-bit significand
    always_ff @(posedge clk) begin
        s2_v    <= s1_v & ~rst;
        s2_sign <= s1_sign;
        s2_nan  <= s1_nan;
        s2_inf  <= s1_inf;
        s2_zero <= s1_zero;
        s2_mode <= s1_mode;
        s2_exp  <= s1_exp + 10'(s1_prod[PROD_W-1]);
        s2_sig  <= s1_prod[PROD_W-1] ? s1_prod[47:24] : s1_prod[46:23];
        s2_g    <= s1_prod[PROD_W-1] ? s1_prod[23] : s1_prod[22];
        s2_r    <= s1_prod[PROD_W-1] ? s1_prod[22] : s1_prod[21];
        s2_st   <= s1_prod[PROD_W-1] ? |s1_prod[21:0] : |s1_prod[20:0];
    end

    logic [SIG_W-1:0]  r_sig;
    logic              r_carry, ovf, unf, to_inf;
    logic signed [9:0] e3;
    res_t              r3;
    fp_round u_round (
        .sign    (s2_sign),
        .sig     (s2_sig),
        .guard   (s2_g),
        .round   (s2_r),
        .sticky  (s2_st),
        .mode    (s2_mode),
        .sig_out (r_sig),
        .carry   (r_carry)
    );
    assign e3     = s2_exp + 10'(r_carry);
    assign ovf    = e3 >= 10'sd255;
    assign unf    = (e3 <= 10'sd0) | ~r_sig[SIG_W-1];
    assign to_inf = (s2_mode == RNE) | (s2_mode == RMM) | ((s2_mode == RUP) & ~s2_sign) | ((s2_mode == RDN) & s2_sign);
    // Stage 3: pick special, saturated, flushed or packed normal result
    always_comb begin
        r3.z    = s2_nan  ? QNAN :
                  s2_inf  ? (s2_sign ? NEG_INF : POS_INF) :
                  s2_zero ? {s2_sign, 31'd0} :
                  ovf     ? (to_inf ? (s2_sign ? NEG_INF : POS_INF) : {s2_sign, MAX_FINITE[30:0]}) :
                  unf     ? {s2_sign, 31'd0} :
                            {s2_sign, e3[EXP_W-1:0], r_sig[MAN_W-1:0]};
        r3.ovrf = ~s2_nan & ~s2_inf & ~s2_zero & ovf;
        r3.udrf = ~s2_nan & ~s2_inf & ~s2_zero & ~ovf & unf;
    end

    logic fv;
    res_t fr;
    generate
        if (LATENCY > 3) begin : g_dly
            localparam int D = LATENCY - 3;
            logic [D-1:0] dv;
            res_t         dr [D];
            // Extra delay stages when more latency than the three compute stages is requested
            always_ff @(posedge clk) begin
                dv[0] <= s2_v & ~rst;
                dr[0] <= r3;
                for (int i = 1; i < D; i++) begin
                    dv[i] <= dv[i-1] & ~rst;
                    dr[i] <= dr[i-1];
                end
            end
            assign fv = dv[D-1];
            assign fr = dr[D-1];
        end else begin : g_nodly
            assign fv = s2_v;
            assign fr = r3;
        end
    endgenerate

    // Output register: load on a valid result, otherwise hold the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            fp_Z      <= '0;
            ovrf      <= 1'b0;
            udrf      <= 1'b0;
        end else begin
            out_valid <= fv;
            if (fv) {fp_Z, ovrf, udrf} <= fr;
        end
    end
endmodule

// File: tb/tb_fp32_mul_pipe.sv
// tb_fp32_mul_pipe: table vectors, reset/back-to-back sequences and random ops against an arithmetic model
module tb_fp32_mul_pipe;
    localparam int LATENCY = 3;
    logic        clk, rst, in_valid, out_valid, ovrf, udrf;
    logic [3:0]  r_mode;
    logic [31:0] fp_X, fp_Y, fp_Z;

    fp32_mul_pipe #(.LATENCY(LATENCY)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .r_mode    (r_mode),
        .fp_X      (fp_X),
        .fp_Y      (fp_Y),
        .out_valid (out_valid),
        .fp_Z      (fp_Z),
        .ovrf      (ovrf),
        .udrf      (udrf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  m;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        ov;
        logic        ud;
    } exp_t;

    typedef struct {
        logic [3:0]  m;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        ov;
        logic        ud;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        pend[$];
    logic [31:0] last_z = 0;
    logic        last_ov = 0, last_ud = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: exact integer product, then round by comparing the discarded remainder with one half
    function automatic exp_t model(input logic [3:0] m, input logic [31:0] x, input logic [31:0] y);
        exp_t            r;
        int              ex, ey, e, msb, k, md;
        logic            s, xz, yz, xi, yi, xn, yn, up;
        longint unsigned mx, my, p, q, rem, half;
        r.v = 1'b1; r.m = m; r.x = x; r.y = y; r.ov = 1'b0; r.ud = 1'b0;
        ex = int'(x[30:23]); ey = int'(y[30:23]); s = x[31] ^ y[31];
        xz = ex == 0; yz = ey == 0;
        xi = ex == 255 && x[22:0] == 0; yi = ey == 255 && y[22:0] == 0;
        xn = ex == 255 && x[22:0] != 0; yn = ey == 255 && y[22:0] != 0;
        md = (m > 4) ? 0 : int'(m);
        if (xn || yn || (xi && yz) || (yi && xz)) r.z = 32'h7FC00000;
        else if (xi || yi) r.z = {s, 8'hFF, 23'd0};
        else if (xz || yz) r.z = {s, 31'd0};
        else begin
            mx = (64'd1 << 23) + 64'(x[22:0]);
            my = (64'd1 << 23) + 64'(y[22:0]);
            p = mx * my;
            msb = 0;
            for (int i = 0; i < 64; i++) if (p[i]) msb = i;
            k = msb - 23;
            q = p >> k;
            rem = p - (q << k);
            half = 64'd1 << (k - 1);
            e = ex + ey - 127 + (msb - 46);
            case (md)
                0: up = (rem > half) || (rem == half && q[0]);
                1: up = 1'b0;
                2: up = s && rem != 0;
                3: up = !s && rem != 0;
                default: up = rem >= half;
            endcase
            q = q + 64'(up);
            if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
            if (e >= 255) begin
                r.ov = 1'b1;
                r.z = (md == 0 || md == 4 || (md == 3 && !s) || (md == 2 && s)) ? {s, 8'hFF, 23'd0} : {s, 31'h7F7FFFFF};
            end else if (e <= 0) begin
                r.ud = 1'b1;
                r.z = {s, 31'd0};
            end else r.z = {s, 8'(e), q[22:0]};
        end
        return r;
    endfunction

    // One cycle: compare the item due this cycle, then drive the next input and queue its expectation
    task automatic step(input logic v, input logic [3:0] m, input logic [31:0] x, input logic [31:0] y, input exp_t e);
        exp_t  p;
        string c;
        @(negedge clk);
        if (pend.size() == LATENCY) begin
            p = pend.pop_front();
            c = $sformatf("m=%0d x=%h y=%h v=%0b", p.m, p.x, p.y, p.v);
            check({"out_valid ", c}, 32'(out_valid), 32'(p.v));
            if (p.v) begin last_z = p.z; last_ov = p.ov; last_ud = p.ud; end
            check({"fp_Z ", c}, fp_Z, last_z);
            check({"ovrf ", c}, 32'(ovrf), 32'(last_ov));
            check({"udrf ", c}, 32'(udrf), 32'(last_ud));
            check({"flags_exclusive ", c}, 32'(ovrf & udrf), 32'd0);
        end
        in_valid = v; r_mode = m; fp_X = x; fp_Y = y;
        e.v = v; e.m = m; e.x = x; e.y = y;
        pend.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0, model(4'd0, 32'd0, 32'd0));
    endtask

    function automatic exp_t from_vec(input vec_t t);
        exp_t r;
        r.v = 1'b1; r.m = t.m; r.x = t.x; r.y = t.y; r.z = t.z; r.ov = t.ov; r.ud = t.ud;
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        logic [31:0] sp [8];
        int          sel;
        sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
               32'h7FC00000, 32'h00000001, 32'h7F7FFFFF, 32'h00800000};
        r = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
            0: ;
            1: r = sp[$urandom_range(0, 7)];
            2: r[30:23] = 8'($urandom_range(1, 40));
            3: r[30:23] = 8'($urandom_range(200, 254));
            default: r[30:23] = 8'($urandom_range(90, 165));
        endcase
        return r;
    endfunction

    vec_t tbl [18];
    logic [3:0]  rm;
    logic [31:0] rx, ry;
    logic        rv;

    initial begin
        tbl = '{
            '{4'd0, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0},
            '{4'd0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0},
            '{4'd3, 32'h3F800001, 32'h3F800001, 32'h3F800003, 1'b0, 1'b0},
            '{4'd1, 32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0},
            '{4'd0, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1'b1, 1'b0},
            '{4'd1, 32'h7F7FFFFF, 32'h40000000, 32'h7F7FFFFF, 1'b1, 1'b0},
            '{4'd3, 32'hFF7FFFFF, 32'h40000000, 32'hFF7FFFFF, 1'b1, 1'b0},
            '{4'd0, 32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1},
            '{4'd0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0},
            '{4'd0, 32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0},
            '{4'd2, 32'hFF7FFFFF, 32'h40000000, 32'hFF800000, 1'b1, 1'b0},
            '{4'd2, 32'hBF800001, 32'h3F800001, 32'hBF800003, 1'b0, 1'b0},
            '{4'd9, 32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0},
            '{4'd0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0},
            '{4'd0, 32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 1'b0},
            '{4'd4, 32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0},
            '{4'd0, 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 1'b0, 1'b0},
            '{4'd4, 32'h3F800003, 32'h3FC00000, 32'h3FC00005, 1'b0, 1'b0}
        };
        rst = 1'b1; in_valid = 1'b0; r_mode = 4'd0; fp_X = '0; fp_Y = '0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1; fp_X = 32'h3F800000; fp_Y = 32'h3F800000;
        repeat (2) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset fp_Z", fp_Z, 32'd0);
        check("reset ovrf", 32'(ovrf), 32'd0);
        check("reset udrf", 32'(udrf), 32'd0);
        rst = 1'b0; in_valid = 1'b0;

        // Isolated single-cycle operations: checks the pulse width and holding between results
        foreach (tbl[i]) begin
            step(1'b1, tbl[i].m, tbl[i].x, tbl[i].y, from_vec(tbl[i]));
            idle(LATENCY);
        end

        // Five back-to-back operations come out on consecutive cycles in order
        for (int i = 0; i < 5; i++) step(1'b1, tbl[i].m, tbl[i].x, tbl[i].y, from_vec(tbl[i]));
        idle(LATENCY);

        // Reset one cycle after the second of two inputs discards both, and an input during reset is ignored
        step(1'b1, tbl[2].m, tbl[2].x, tbl[2].y, from_vec(tbl[2]));
        step(1'b1, tbl[4].m, tbl[4].x, tbl[4].y, from_vec(tbl[4]));
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; fp_X = 32'h40000000; fp_Y = 32'h40000000;
        pend.delete();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < LATENCY + 2; i++) begin
            if (i > 0) @(negedge clk);
            check("post-reset out_valid", 32'(out_valid), 32'd0);
            check("post-reset fp_Z", fp_Z, 32'd0);
            check("post-reset ovrf", 32'(ovrf), 32'd0);
            check("post-reset udrf", 32'(udrf), 32'd0);
        end
        last_z = '0; last_ov = 1'b0; last_ud = 1'b0;

        // Random traffic with gaps, all modes including the out-of-range encodings
        repeat (3000) begin
            rv = $urandom_range(0, 3) != 0;
            rm = 4'($urandom_range(0, 15));
            rx = rand_op();
            ry = rand_op();
            step(rv, rm, rx, ry, model(rm, rx, ry));
        end
        idle(LATENCY + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp32_mul_pipe.md
FP32_MUL_PIPE -- requirements
Module: fp32_mul_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: the clock port is clk and the reset port is rst.
REQ-002 Parameter: LATENCY, default 3, fixed number of clk cycles from input sample to result.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  r_mode/fp_X/fp_Y are sampled this cycle.
REQ-006 r_mode  input  4  rounding mode: 0 RNE, 1 RTZ, 2 RDN (toward -inf), 3 RUP (toward +inf), 4 RMM (ties away); 5-15 treated as RNE.
REQ-007 fp_X  input  32  IEEE-754 binary32 operand.
REQ-008 fp_Y  input  32  IEEE-754 binary32 operand.
REQ-009 out_valid  output  1  fp_Z/ovrf/udrf carry a new result this cycle.
REQ-010 fp_Z  output  32  binary32 product.
REQ-011 ovrf  output  1  rounded result exceeded the max finite magnitude.
REQ-012 udrf  output  1  nonzero exact result was below the min normal magnitude and was flushed.

Function
REQ-013 Pipeline SHALL be fully pipelined: one new operation per cycle accepted; there is no backpressure.
REQ-014 in_valid high at rising edge N SHALL produce out_valid high at edge N+3 with that operation's result; out_valid SHALL be low in cycles with no matching input.
REQ-015 fp_Z/ovrf/udrf SHALL hold their last value while out_valid is low.
REQ-016 Stage 1 SHALL unpack the operands, detect special cases, form the sign as XOR and the biased exponent sum ex+ey-127 (10-bit signed), and register the 48-bit product of the 24-bit significands.
REQ-017 Stage 2 SHALL normalize: if product bit 47 is set, shift right by 1 and increment the exponent; it SHALL form a 24-bit significand plus guard, round and sticky bits (sticky = OR of all remaining bits).
REQ-018 Stage 3 SHALL round per r_mode; a rounding carry-out SHALL renormalize the result and increment the exponent.
REQ-019 Subnormal inputs SHALL be treated as signed zero (flush-to-zero).
REQ-020 A final exponent >= 255 SHALL set ovrf=1; the result is ±inf for RNE/RMM, for RUP when positive and for RDN when negative; it is ±0x7F7FFFFF for RTZ and for the other directed cases.
REQ-021 A final exponent <= 0 with nonzero operands SHALL set udrf=1 and the result SHALL be signed zero.
REQ-022 If either operand is NaN, or inf is multiplied by zero, the result SHALL be 0x7FC00000 with ovrf=udrf=0.
REQ-023 inf times finite-nonzero or inf SHALL give signed inf with ovrf=0; zero times finite SHALL give signed zero with udrf=0.
REQ-024 ovrf and udrf SHALL never both be 1.

Reset
REQ-025 While rst is high at a clk edge, all valid bits in the pipeline and out_valid SHALL clear, and fp_Z, ovrf and udrf SHALL be 0.
REQ-026 Operations in flight when rst asserts SHALL be discarded; no out_valid is produced for them after rst deasserts.
REQ-027 in_valid sampled during rst SHALL be ignored.
REQ-028 Datapath registers other than the valid bits need no reset.

Structure
REQ-029 A shared package fp_mul_pkg SHALL hold the rounding-mode enum, EXP_BIAS=127, the field widths, QNAN=32'h7FC00000, POS_INF, NEG_INF and MAX_FINITE.
REQ-030 Stage-3 rounding SHALL be a sub-module fp_round; it is combinational and its inputs are sign, significand, guard, round, sticky and mode; its outputs are the rounded significand and the carry.

Verification
REQ-031 RNE, in_valid one cycle, 0x3FC00000 x 0x40000000 -> three cycles later out_valid=1 for one cycle, fp_Z=0x40400000, ovrf=udrf=0.
REQ-032 0x3F800001 x 0x3F800001 -> RNE 0x3F800002; RUP 0x3F800003; RTZ 0x3F800002.
REQ-033 0x7F7FFFFF x 0x40000000 -> RNE 0x7F800000 ovrf=1; RTZ 0x7F7FFFFF ovrf=1; with fp_X=0xFF7FFFFF under RUP -> 0xFF7FFFFF ovrf=1.
REQ-034 0x00800000 x 0x3F000000 -> 0x00000000 udrf=1; 0x7F800000 x 0x00000000 -> 0x7FC00000; 0x80000000 x 0x40000000 -> 0x80000000.
REQ-035 Back-to-back inputs in 5 consecutive cycles -> 5 consecutive correct results in order; rst pulsed one cycle after the 2nd input -> no out_valid for inputs 1-2 and all outputs 0.
